// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue feeding {IR, NPC} pairs to the IF stage over valid/ready.
// Optional feature FQ_HLT_STOP_EN: stop fetching after a stored HLT word until redirect.
module mips_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_ack,
  input  logic [DW-1:0]          imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [DW-1:0]          inst_ir,
  output logic [31:0]            inst_npc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic          hlt_stop;

  logic [DW-1:0] ir_mem  [DEPTH];
  logic [NW-1:0] npc_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          push;
  logic          pop;
  logic          can_issue;
  logic [NW-1:0] push_npc;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [DW-1:0] ir_nxt;
  logic [31:0]   npc_nxt;

  // Queue bookkeeping; redirect overrides push and pop in the same cycle.
  always_comb begin
    push      = (state == S_WAIT) && imem_ack && !redirect_valid;
    pop       = inst_valid && inst_ready && !redirect_valid;
    push_npc  = NW'(imem_addr) + NW'(1);
    can_issue = !halt && !redirect_valid && !hlt_stop && (count < CW'(DEPTH));
    if (redirect_valid) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      count_nxt  = count + CW'(push) - CW'(pop);
      rd_ptr_nxt = rd_ptr + PW'(pop);
      wr_ptr_nxt = wr_ptr + PW'(push);
    end
    // Head is registered: take the incoming word directly when it lands in an empty queue.
    ir_nxt  = inst_ir;
    npc_nxt = inst_npc;
    if (count_nxt != '0) begin
      if (push && (count == CW'(pop))) begin
        ir_nxt  = imem_rdata;
        npc_nxt = 32'(push_npc);
      end else begin
        ir_nxt  = ir_mem[rd_ptr_nxt];
        npc_nxt = 32'(npc_mem[rd_ptr_nxt]);
      end
    end
  end

  // Fetch FSM: one request outstanding; DROP swallows the ack of a request cut by a redirect.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_pc  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end else if (can_issue) begin
            state     <= S_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= S_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + AW'(1);
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        S_DROP: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FQ_HLT_STOP_EN
  localparam logic [5:0] HLT_OP = 6'b000110;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      hlt_stop <= 1'b0;
    end else if (redirect_valid) begin
      hlt_stop <= 1'b0;
    end else if (push && (imem_rdata[31:26] == HLT_OP)) begin
      hlt_stop <= 1'b1;
    end
  end
`else
  assign hlt_stop = 1'b0;
`endif

  // Queue control and registered head outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_ir    <= '0;
      inst_npc   <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      inst_valid <= (count_nxt != '0);
      inst_ir    <= ir_nxt;
      inst_npc   <= npc_nxt;
    end
  end

  // Entry storage; slot reservation guarantees wr_ptr never overwrites a live entry.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= push_npc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: variable-latency memory model plus a word-stream scoreboard.
module tb_mips_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 3;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_ir;
  logic [31:0]   inst_npc;
  logic [CW-1:0] count;

  always #5 clk1 = ~clk1;

  mips_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk1(clk1), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_ir(inst_ir), .inst_npc(inst_npc), .count(count)
  );

  logic [31:0] mem [1024];
  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  int            lat_min = 0, lat_max = 0;
  bit            busy = 0, dropped = 0;
  int            cnt = 0;
  logic [AW-1:0] req_addr = '0;
  // scoreboard state
  int            n_req = 0, n_pop = 0;
  logic [AW-1:0] last_req_addr = '0;
  logic [31:0]   last_pop_ir = '0, last_pop_npc = '0;
  int            mcount = 0;
  logic [AW-1:0] exp_req = '0, exp_del = '0;
  bit            mstop = 0;
  bit            prev_halt = 0, prev_redir = 0, prev_stop = 0;
  int            prev_mcount = 0;

  // Memory responder and reference model, evaluated mid-cycle when everything is stable.
  task automatic mon();
    if (!rst_n) begin
      imem_ack = 0; busy = 0; dropped = 0; mcount = 0; exp_req = '0; exp_del = '0;
      mstop = 0; prev_halt = 0; prev_redir = 0; prev_stop = 0; prev_mcount = 0;
      n_req = 0; n_pop = 0;
      return;
    end
    if (imem_ack) begin imem_ack = 0; busy = 0; dropped = 0; end
    if (busy) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== req_addr) begin
        n_fail++;
        $display("FAIL req_hold: req=%b addr=%0d, required req=1 addr=%0d", imem_req, imem_addr, req_addr);
      end
      if (cnt == 0) begin imem_ack = 1; imem_rdata = mem[req_addr]; end
      else cnt--;
    end else if (imem_req === 1'b1) begin
      n_tests++;
      if (prev_halt || prev_redir || prev_stop || prev_mcount >= DEPTH || imem_addr !== exp_req) begin
        n_fail++;
        $display("FAIL req_issue: addr=%0d halt=%b redir=%b stop=%b count=%0d, required addr=%0d issued only when free",
                 imem_addr, prev_halt, prev_redir, prev_stop, prev_mcount, exp_req);
      end
      busy = 1; req_addr = imem_addr; cnt = int'($urandom_range(lat_max, lat_min));
      n_req++; last_req_addr = imem_addr;
    end
    n_tests++;
    if (count !== CW'(mcount) || inst_valid !== (mcount != 0)) begin
      n_fail++;
      $display("FAIL occupancy: count=%0d valid=%b, required count=%0d valid=%b", count, inst_valid, mcount, mcount != 0);
    end
    if (mcount != 0) begin
      n_tests++;
      if (inst_ir !== mem[exp_del] || inst_npc !== 32'(exp_del) + 32'd1) begin
        n_fail++;
        $display("FAIL head: ir=%h npc=%0d, required ir=%h npc=%0d", inst_ir, inst_npc, mem[exp_del], 32'(exp_del) + 32'd1);
      end
    end
    prev_halt = halt; prev_redir = redirect_valid; prev_stop = mstop; prev_mcount = mcount;
    if (redirect_valid) begin
      mcount = 0; exp_req = redirect_pc; exp_del = redirect_pc; mstop = 0;
      if (busy) dropped = 1;
    end else begin
      if (inst_ready && mcount != 0) begin
        last_pop_ir = inst_ir; last_pop_npc = inst_npc; n_pop++; exp_del++; mcount--;
      end
      if (imem_ack && !dropped) begin
        mcount++; exp_req++;
`ifdef FQ_HLT_STOP_EN
        if (imem_rdata[31:26] == 6'b000110) mstop = 1;
`endif
      end
    end
  endtask

  task automatic step();
    @(negedge clk1); mon();
    @(posedge clk1); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; redirect_valid = 0; halt = 0; inst_ready = 0; redirect_pc = '0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic pulse_redirect(input logic [AW-1:0] pc);
    redirect_valid = 1; redirect_pc = pc;
    step();
    redirect_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({imem_req, imem_addr, inst_valid, inst_ir, inst_npc, count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b addr=%0d valid=%b ir=%h npc=%0d count=%0d, required all 0",
               imem_req, imem_addr, inst_valid, inst_ir, inst_npc, count);
    end
    lat_min = 0; lat_max = 0;
    repeat (20) step();
    rst_n = 0; #1;
    n_tests++;
    if ({imem_req, imem_addr, inst_valid, inst_ir, inst_npc, count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b addr=%0d valid=%b ir=%h npc=%0d count=%0d, required all 0",
               imem_req, imem_addr, inst_valid, inst_ir, inst_npc, count);
    end
    step();
  endtask

  task automatic test_stream();
    int t;
    do_reset();
    lat_min = 0; lat_max = 0; inst_ready = 1;
    t = 0; while (n_pop < 1 && t < 50) begin step(); t++; end
    n_tests++;
    if (n_pop < 1 || last_pop_ir !== mem[0] || last_pop_npc !== 32'd1) begin
      n_fail++;
      $display("FAIL stream_first: pops=%0d ir=%h npc=%0d, required ir=%h npc=1", n_pop, last_pop_ir, last_pop_npc, mem[0]);
    end
    t = 0; while (n_pop < 2 && t < 50) begin step(); t++; end
    n_tests++;
    if (n_pop < 2 || last_pop_ir !== mem[1] || last_pop_npc !== 32'd2) begin
      n_fail++;
      $display("FAIL stream_second: pops=%0d ir=%h npc=%0d, required ir=%h npc=2", n_pop, last_pop_ir, last_pop_npc, mem[1]);
    end
    repeat (40) step();
    n_tests++;
    if (n_pop < 10) begin
      n_fail++;
      $display("FAIL stream_rate: pops=%0d, required at least 10", n_pop);
    end
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    lat_min = 3; lat_max = 3; inst_ready = 0;
    t = 0; while (count !== CW'(DEPTH) && t < 200) begin step(); t++; end
    repeat (20) step();
    n_tests++;
    if (count !== CW'(DEPTH) || imem_req !== 1'b0 || n_req != DEPTH) begin
      n_fail++;
      $display("FAIL full_stall: count=%0d req=%b requests=%0d, required count=4 req=0 requests=4", count, imem_req, n_req);
    end
    inst_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++;
      if (count !== CW'(DEPTH - i)) begin
        n_fail++;
        $display("FAIL drain_%0d: count=%0d, required %0d", i, count, DEPTH - i);
      end
    end
    t = 0; while (n_req <= DEPTH && t < 50) begin step(); t++; end
    n_tests++;
    if (n_req <= DEPTH || last_req_addr !== AW'(DEPTH)) begin
      n_fail++;
      $display("FAIL refetch: requests=%0d addr=%0d, required a 5th request at addr 4", n_req, last_req_addr);
    end
  endtask

  task automatic test_redirect_drop();
    int t, n0;
    do_reset();
    lat_min = 1; lat_max = 1; inst_ready = 1;
    t = 0; while (imem_req !== 1'b1 && t < 20) begin step(); t++; end
    pulse_redirect(AW'(10'h040));
    n0 = n_req;
    t = 0; while (n_req == n0 && t < 50) begin step(); t++; end
    n_tests++;
    if (n_req == n0 || last_req_addr !== AW'(10'h040)) begin
      n_fail++;
      $display("FAIL redirect_addr: requests=%0d addr=%0d, required new request at 64", n_req - n0, last_req_addr);
    end
    t = 0; while (n_pop < 1 && t < 50) begin step(); t++; end
    n_tests++;
    if (n_pop < 1 || last_pop_npc !== 32'h41 || last_pop_ir !== mem[10'h040]) begin
      n_fail++;
      $display("FAIL redirect_first: npc=%0d ir=%h, required npc=65 ir=%h", last_pop_npc, last_pop_ir, mem[10'h040]);
    end
  endtask

  task automatic test_redirect_collide();
    int t, n0;
    logic [AW-1:0] tgt;
    do_reset();
    lat_min = 2; lat_max = 2; inst_ready = 0;
    tgt = AW'($urandom_range(1023, 100));
    t = 0;
    while (!(count === CW'(2) && busy && cnt == 0 && !imem_ack) && t < 200) begin step(); t++; end
    n_tests++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL collide_setup: count=%0d busy=%b, required count=2 with ack due", count, busy);
    end
    inst_ready = 1;
    pulse_redirect(tgt);
    n_tests++;
    if (count !== '0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_flush: count=%0d valid=%b, required count=0 valid=0", count, inst_valid);
    end
    n0 = n_req;
    t = 0; while (n_req == n0 && t < 20) begin step(); t++; end
    n_tests++;
    if (n_req == n0 || last_req_addr !== tgt) begin
      n_fail++;
      $display("FAIL collide_addr: addr=%0d, required %0d", last_req_addr, tgt);
    end
  endtask

  task automatic test_wrap();
    int t;
    do_reset();
    lat_min = 0; lat_max = 2; inst_ready = 1;
    pulse_redirect(AW'(1023));
    t = 0; while (n_req < 1 && t < 20) begin step(); t++; end
    n_tests++;
    if (n_req < 1 || last_req_addr !== AW'(1023)) begin
      n_fail++;
      $display("FAIL wrap_req0: addr=%0d, required 1023", last_req_addr);
    end
    t = 0; while (n_req < 2 && t < 30) begin step(); t++; end
    n_tests++;
    if (n_req < 2 || last_req_addr !== '0) begin
      n_fail++;
      $display("FAIL wrap_req1: addr=%0d, required 0", last_req_addr);
    end
    t = 0; while (n_pop < 1 && t < 30) begin step(); t++; end
    n_tests++;
    if (n_pop < 1 || last_pop_npc !== 32'd1024 || last_pop_ir !== mem[1023]) begin
      n_fail++;
      $display("FAIL wrap_npc: npc=%0d ir=%h, required npc=1024 ir=%h", last_pop_npc, last_pop_ir, mem[1023]);
    end
    t = 0; while (n_pop < 2 && t < 30) begin step(); t++; end
    n_tests++;
    if (n_pop < 2 || last_pop_npc !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_next: npc=%0d, required 1", last_pop_npc);
    end
  endtask

  task automatic test_hlt();
    int t;
    logic [31:0] saved;
    saved = mem[5];
    do_reset();
    mem[5] = 32'h1800_0000;
    lat_min = 0; lat_max = 1; inst_ready = 1;
    t = 0; while (n_pop < 6 && t < 200) begin step(); t++; end
    n_tests++;
    if (n_pop < 6 || last_pop_npc !== 32'd6 || last_pop_ir !== 32'h1800_0000) begin
      n_fail++;
      $display("FAIL hlt_delivered: pops=%0d npc=%0d ir=%h, required word 5 = 18000000 delivered", n_pop, last_pop_npc, last_pop_ir);
    end
`ifdef FQ_HLT_STOP_EN
    repeat (30) step();
    n_tests++;
    if (n_req != 6 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_stop: requests=%0d req=%b, required 6 requests and req=0", n_req, imem_req);
    end
    pulse_redirect('0);
    t = 0; while (n_req == 6 && t < 20) begin step(); t++; end
    n_tests++;
    if (n_req == 6 || last_req_addr !== '0) begin
      n_fail++;
      $display("FAIL hlt_resume: addr=%0d, required request at 0", last_req_addr);
    end
`else
    t = 0; while (n_req < 7 && t < 50) begin step(); t++; end
    n_tests++;
    if (n_req < 7 || last_req_addr !== AW'(6)) begin
      n_fail++;
      $display("FAIL hlt_ignored: requests=%0d addr=%0d, required request at 6", n_req, last_req_addr);
    end
`endif
    do_reset();
    mem[5] = saved;
  endtask

  task automatic test_halt();
    int t, n0;
    do_reset();
    lat_min = 0; lat_max = 3; inst_ready = 1;
    repeat (10) step();
    halt = 1;
    repeat (10) step();
    n0 = n_req;
    repeat (15) step();
    n_tests++;
    if (n_req != n0 || imem_req !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL halt_block: new_requests=%0d req=%b count=%0d, required 0 0 0", n_req - n0, imem_req, count);
    end
    halt = 0;
    t = 0; while (n_req == n0 && t < 20) begin step(); t++; end
    n_tests++;
    if (n_req == n0 || last_req_addr !== last_pop_npc[AW-1:0]) begin
      n_fail++;
      $display("FAIL halt_resume: addr=%0d, required %0d", last_req_addr, last_pop_npc[AW-1:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 0; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      inst_ready     = ($urandom_range(3, 0) != 0);
      halt           = ($urandom_range(15, 0) == 0);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = AW'($urandom);
      step();
    end
    redirect_valid = 0; halt = 0;
    n_tests++;
    if (n_pop < 100) begin
      n_fail++;
      $display("FAIL random_progress: pops=%0d, required at least 100", n_pop);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'b000110) w[31] = 1'b1;
      mem[i] = w;
    end
    @(posedge clk1); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_wrap();
    test_hlt();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
